// File: rtl/fp16_acc_seq_pkg.sv
// rtl/fp16_acc_seq_pkg.sv - shared FSM state type and FP16 format constants
package fp16_acc_seq_pkg;

  localparam int FP16_W   = 16;
  localparam int EXP_BITS = 5;
  localparam int MAN_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/new_fp16_add.sv
// rtl/new_fp16_add.sv - combinational FP16 adder, round-to-nearest-even
// Both operands are assumed non-zero; the caller bypasses zeros.
module new_fp16_add
  import fp16_acc_seq_pkg::*;
(
  input  logic [1:0][FP16_W-1:0] op_i,
  output logic [FP16_W-1:0]      sum_o
);

  logic [FP16_W-1:0]   big, sml;
  logic [5:0]          e_big, e_sml, e_diff, e_norm, lz, sh;
  logic [MAN_BITS:0]   m_big, m_sml;
  logic [39:0]         sml_sh;
  logic [14:0]         raw;
  logic [13:0]         m_norm;
  logic [EXP_BITS-1:0] e_fld;
  logic                rnd;
  logic [14:0]         rounded;

  always_comb begin
    if (op_i[0][14:0] > op_i[1][14:0]) begin
      big = op_i[0];
      sml = op_i[1];
    end else begin
      big = op_i[1];
      sml = op_i[0];
    end
    // Subnormals share the exponent of the smallest normal and have no hidden one
    e_big  = (big[14:10] == 5'd0) ? 6'd1 : {1'b0, big[14:10]};
    e_sml  = (sml[14:10] == 5'd0) ? 6'd1 : {1'b0, sml[14:10]};
    m_big  = {big[14:10] != 5'd0, big[9:0]};
    m_sml  = {sml[14:10] != 5'd0, sml[9:0]};
    e_diff = e_big - e_sml;
    sml_sh = {m_sml, 29'd0} >> e_diff;

    // 14-bit working mantissa: 11 significand bits, guard, round, sticky
    if (big[15] ^ sml[15]) begin
      raw = {1'b0, m_big, 3'b000} - {1'b0, sml_sh[39:27], |sml_sh[26:0]};
    end else begin
      raw = {1'b0, m_big, 3'b000} + {1'b0, sml_sh[39:27], |sml_sh[26:0]};
    end

    lz = 6'd14;
    for (int i = 0; i < 14; i++) begin
      if (raw[i]) lz = 6'(13 - i);
    end
    sh = (lz < e_big - 6'd1) ? lz : e_big - 6'd1;

    if (raw[14]) begin
      m_norm = {raw[14:2], raw[1] | raw[0]};
      e_norm = e_big + 6'd1;
    end else begin
      m_norm = raw[13:0] << sh;
      e_norm = e_big - sh;
    end

    // Rounding carry ripples into the exponent field, covering subnormal->normal and ->inf
    e_fld   = m_norm[13] ? e_norm[4:0] : 5'd0;
    rnd     = m_norm[2] & (m_norm[3] | m_norm[1] | m_norm[0]);
    rounded = {e_fld, m_norm[12:3]} + 15'(rnd);

    sum_o = {big[15], rounded};
    if (rounded == 15'd0) sum_o = 16'h0000;
    if (e_norm >= 6'd31 || rounded[14:10] == 5'd31) sum_o = {big[15], 15'h7C00};
    if (big[14:10] == 5'd31) begin
      if (big[9:0] != 10'd0 || (sml[14:10] == 5'd31 && sml[15] != big[15])) begin
        sum_o = 16'h7E00;
      end else begin
        sum_o = big;
      end
    end
  end

endmodule

// File: rtl/fp16_acc_seq.sv
// rtl/fp16_acc_seq.sv - streaming FP16 packet accumulator with registered result handshake
module fp16_acc_seq
  import fp16_acc_seq_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [15:0]       in_data_i,
  input  logic              in_last_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [15:0]       sum_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o,
  output logic              sum_valid_o,
  input  logic              sum_ready_i,
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic [15:0]       acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       add_sum;
  logic [CNT_W-1:0]  cnt_inc;

  new_fp16_add u_add (
    .op_i  ({acc_q, in_data_i}),
    .sum_o (add_sum)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (flush_i) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            acc_d   = in_data_i;
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = in_last_i ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid_i) begin
            cnt_d = cnt_inc;
            // Zero elements only count; a zero accumulator is replaced instead of added
            if (in_data_i[14:0] != 15'd0) begin
              acc_d = (acc_q[14:0] == 15'd0) ? in_data_i : add_sum;
            end
            if (in_last_i) begin
              state_d = DONE;
            end else if (cnt_inc == CNT_W'(MAX_LEN)) begin
              state_d = DONE;
              ovf_d   = 1'b1;
            end
          end
        end
        DONE: begin
          if (sum_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q != DONE);
  assign sum_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign sum_o       = acc_q;
  assign count_o     = cnt_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_fp16_acc_seq.sv
// tb/tb_fp16_acc_seq.sv - scoreboard bench for fp16_acc_seq with a real-arithmetic adder model
module tb_fp16_acc_seq;

  localparam int MAXL = 4;
  localparam int CW   = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic [15:0]   in_data_i = 16'h0;
  logic          in_last_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [15:0]   sum_o;
  logic [CW-1:0] count_o;
  logic          ovf_o;
  logic          sum_valid_o;
  logic          sum_ready_i = 1'b1;
  logic          busy_o;

  fp16_acc_seq #(.MAX_LEN(MAXL)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sum_o       (sum_o),
    .count_o     (count_o),
    .ovf_o       (ovf_o),
    .sum_valid_o (sum_valid_o),
    .sum_ready_i (sum_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0]   sum;
    logic [CW-1:0] cnt;
    logic          ovf;
  } res_t;

  res_t          exp_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            n_dut_results = 0;
  int            m_state = 0;
  logic [15:0]   m_acc = 16'h0;
  logic [CW-1:0] m_cnt = '0;
  logic          m_ovf = 1'b0;

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [15:0] h);
    real v;
    if (h[14:10] == 5'd0) v = real'(h[9:0]) * pow2(-24);
    else v = real'({1'b1, h[9:0]}) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2f(input real r);
    real a, q, n, frac;
    int e, fl;
    logic [15:0] bits;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = -24;
    while (e < 20 && pow2(e + 1) <= a) e++;
    q = (e < -14) ? pow2(-24) : pow2(e - 10);
    n = a / q;
    fl = $rtoi(n);
    frac = n - real'(fl);
    if (frac > 0.5 || (frac == 0.5 && (fl % 2) == 1)) fl++;
    if (e < -14) bits = 16'(fl);
    else bits = 16'((e + 15) * 1024 + fl - 1024);
    if (bits >= 16'h7C00) bits = 16'h7C00;
    return {s, bits[14:0]};
  endfunction

  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [15:0] rand_fp16();
    logic [15:0] v;
    if ($urandom_range(0, 7) == 0) v = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000;
    else v = {1'($urandom_range(0, 1)), 5'($urandom_range(5, 22)), 10'($urandom_range(0, 1023))};
    return v;
  endfunction

  // Monitor and reference model: compare at negedge+2, then predict the next posedge
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_ni) begin
        m_state = 0; m_acc = 16'h0; m_cnt = '0; m_ovf = 1'b0;
        exp_q.delete();
      end else begin
        n_chk++;
        if (in_ready_o !== (m_state != 2)) begin
          n_fail++; $display("FAIL mon_in_ready: got %b expected %b", in_ready_o, m_state != 2);
        end
        n_chk++;
        if (sum_valid_o !== (m_state == 2)) begin
          n_fail++; $display("FAIL mon_sum_valid: got %b expected %b", sum_valid_o, m_state == 2);
        end
        n_chk++;
        if (busy_o !== (m_state != 0)) begin
          n_fail++; $display("FAIL mon_busy: got %b expected %b", busy_o, m_state != 0);
        end
        n_chk++;
        if ({sum_o, count_o, ovf_o} !== {m_acc, m_cnt, m_ovf}) begin
          n_fail++; $display("FAIL mon_regs: got sum=%h cnt=%0d ovf=%b expected sum=%h cnt=%0d ovf=%b",
                             sum_o, count_o, ovf_o, m_acc, m_cnt, m_ovf);
        end
        if (m_state == 2) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL sb_empty: got result %h with no expected entry", sum_o);
          end else if ({sum_o, count_o, ovf_o} !== exp_q[0]) begin
            n_fail++; $display("FAIL sb_result: got sum=%h cnt=%0d ovf=%b expected sum=%h cnt=%0d ovf=%b",
                               sum_o, count_o, ovf_o, exp_q[0].sum, exp_q[0].cnt, exp_q[0].ovf);
          end
        end
        if (sum_valid_o && sum_ready_i && !flush_i) n_dut_results++;

        if (flush_i) begin
          m_state = 0; m_acc = 16'h0; m_cnt = '0; m_ovf = 1'b0;
          exp_q.delete();
        end else if (m_state == 2) begin
          if (sum_ready_i) begin
            void'(exp_q.pop_front());
            m_state = 0;
          end
        end else if (in_valid_i) begin
          if (m_state == 0) begin
            m_acc = in_data_i; m_cnt = CW'(1); m_ovf = 1'b0;
          end else begin
            m_cnt = m_cnt + 1'b1;
            if (in_data_i[14:0] != 15'd0)
              m_acc = (m_acc[14:0] == 15'd0) ? in_data_i : model_add(m_acc, in_data_i);
          end
          if (in_last_i) m_state = 2;
          else if (m_cnt == CW'(MAXL)) begin m_state = 2; m_ovf = 1'b1; end
          else m_state = 1;
          if (m_state == 2) exp_q.push_back({m_acc, m_cnt, m_ovf});
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic l);
    int w = 0;
    in_valid_i = 1'b1; in_data_i = d; in_last_i = l;
    while (!in_ready_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    if (w >= 20) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got in_ready=%b expected 1 within 20 cycles", in_ready_o);
    end
    @(negedge clk_i);
    in_valid_i = 1'b0; in_last_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready_o); end
    n_chk++; if (sum_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_sum_valid: got %b expected 0", sum_valid_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    n_chk++; if (sum_o !== 16'h0000) begin n_fail++; $display("FAIL rst_sum: got %h expected 0000", sum_o); end
    n_chk++; if (count_o !== '0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count_o); end
    n_chk++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", ovf_o); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single();
    send(16'hC500, 1'b1);
    n_chk++; if (sum_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_latency: got sum_valid=%b expected 1", sum_valid_o); end
    n_chk++; if (sum_o !== 16'hC500) begin n_fail++; $display("FAIL single_sum: got %h expected c500", sum_o); end
    n_chk++; if (count_o !== CW'(1)) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count_o); end
    n_chk++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL single_ovf: got %b expected 0", ovf_o); end
    @(negedge clk_i);
  endtask

  task automatic test_two();
    logic [15:0] e;
    e = model_add(16'h3C00, 16'h3C00);
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b1);
    n_chk++; if (sum_o !== e) begin n_fail++; $display("FAIL two_sum: got %h expected %h", sum_o, e); end
    n_chk++; if (count_o !== CW'(2)) begin n_fail++; $display("FAIL two_count: got %0d expected 2", count_o); end
    @(negedge clk_i);
  endtask

  task automatic test_zeros();
    send(16'h0000, 1'b0);
    send(16'h3C00, 1'b0);
    send(16'h8000, 1'b1);
    n_chk++; if (sum_o !== 16'h3C00) begin n_fail++; $display("FAIL zeros_sum: got %h expected 3c00", sum_o); end
    n_chk++; if (count_o !== CW'(3)) begin n_fail++; $display("FAIL zeros_count: got %0d expected 3", count_o); end
    @(negedge clk_i);
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    e = model_add(16'h3800, 16'h3400);
    sum_ready_i = 1'b0;
    send(16'h3800, 1'b0);
    send(16'h3400, 1'b1);
    in_valid_i = 1'b1; in_data_i = 16'h4200; in_last_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_chk++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b expected 0", c, in_ready_o); end
      n_chk++; if (sum_o !== e) begin n_fail++; $display("FAIL bp_hold_sum c%0d: got %h expected %h", c, sum_o, e); end
      @(negedge clk_i);
    end
    sum_ready_i = 1'b1;
    @(negedge clk_i);
    n_chk++; if (sum_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_consume: got valid=%b ready=%b expected valid=0 ready=1", sum_valid_o, in_ready_o);
    end
    @(negedge clk_i);
    in_valid_i = 1'b0; in_last_i = 1'b0;
    n_chk++; if (sum_o !== 16'h4200 || count_o !== CW'(1)) begin
      n_fail++; $display("FAIL bp_next: got sum=%h cnt=%0d expected sum=4200 cnt=1", sum_o, count_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_flush();
    int r0;
    r0 = n_dut_results;
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b0);
    flush_i = 1'b1; in_valid_i = 1'b1; in_data_i = 16'h5000; in_last_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0; in_valid_i = 1'b0; in_last_i = 1'b0;
    n_chk++; if (busy_o !== 1'b0 || count_o !== '0 || sum_o !== 16'h0000) begin
      n_fail++; $display("FAIL flush_clear: got busy=%b cnt=%0d sum=%h expected 0/0/0000", busy_o, count_o, sum_o);
    end
    send(16'h4000, 1'b1);
    n_chk++; if (sum_o !== 16'h4000 || count_o !== CW'(1) || ovf_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_next: got sum=%h cnt=%0d ovf=%b expected 4000/1/0", sum_o, count_o, ovf_o);
    end
    n_chk++; if (n_dut_results !== r0) begin
      n_fail++; $display("FAIL flush_no_result: got %0d results expected %0d", n_dut_results, r0);
    end
    @(negedge clk_i);
  endtask

  task automatic test_overflow();
    logic [15:0] e;
    e = model_add(model_add(model_add(16'h3C00, 16'h3C00), 16'h3C00), 16'h3C00);
    for (int i = 0; i < 4; i++) send(16'h3C00, 1'b0);
    n_chk++; if (sum_valid_o !== 1'b1 || ovf_o !== 1'b1 || count_o !== CW'(4)) begin
      n_fail++; $display("FAIL ovf_close: got valid=%b ovf=%b cnt=%0d expected 1/1/4", sum_valid_o, ovf_o, count_o);
    end
    n_chk++; if (sum_o !== e) begin n_fail++; $display("FAIL ovf_sum: got %h expected %h", sum_o, e); end
    send(16'h3C00, 1'b0);
    n_chk++; if (busy_o !== 1'b1 || sum_valid_o !== 1'b0 || count_o !== CW'(1) || ovf_o !== 1'b0 || sum_o !== 16'h3C00) begin
      n_fail++; $display("FAIL ovf_fifth: got busy=%b valid=%b cnt=%0d ovf=%b sum=%h expected 1/0/1/0/3c00",
                         busy_o, sum_valid_o, count_o, ovf_o, sum_o);
    end
    send(16'h3C00, 1'b1);
    n_chk++; if (count_o !== CW'(2) || sum_o !== 16'h4000) begin
      n_fail++; $display("FAIL ovf_tail: got cnt=%0d sum=%h expected 2/4000", count_o, sum_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    int r0;
    r0 = n_dut_results;
    send(16'h3C00, 1'b0);
    send(16'h4400, 1'b0);
    #3 rst_ni = 1'b0;
    #1;
    n_chk++; if (busy_o !== 1'b0 || in_ready_o !== 1'b1 || sum_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ctrl: got busy=%b ready=%b valid=%b expected 0/1/0", busy_o, in_ready_o, sum_valid_o);
    end
    n_chk++; if (sum_o !== 16'h0000 || count_o !== '0 || ovf_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_regs: got sum=%h cnt=%0d ovf=%b expected 0000/0/0", sum_o, count_o, ovf_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    n_chk++; if (n_dut_results !== r0) begin
      n_fail++; $display("FAIL midrst_no_result: got %0d results expected %0d", n_dut_results, r0);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = n_dut_results;
    for (int c = 0; c < 400; c++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      in_data_i   = rand_fp16();
      in_last_i   = ($urandom_range(0, 3) == 0);
      sum_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 39) == 0);
      @(negedge clk_i);
    end
    in_valid_i = 1'b0; in_last_i = 1'b0; flush_i = 1'b0; sum_ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    n_chk++; if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: got %0d pending results expected 0", exp_q.size());
    end
    n_chk++; if (n_dut_results <= r0 + 20) begin
      n_fail++; $display("FAIL b2b_throughput: got %0d results expected more than 20", n_dut_results - r0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_two();
    test_zeros();
    test_backpressure();
    test_flush();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp16_acc_seq.md
FP16_ACC_SEQ -- requirements
Module: fp16_acc_seq

Interface
REQ-001 SHALL have parameter MAX_LEN, default 256: maximum number of elements per packet, at least 2.
REQ-002 SHALL have parameter CNT_W, default $clog2(MAX_LEN+1): width of the element counter.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i, input, 1 bit: synchronous abort of the current packet.
REQ-006 SHALL have port in_data_i, input, 16 bits: FP16 element (1-5-10).
REQ-007 SHALL have port in_last_i, input, 1 bit: marks the final element of a packet.
REQ-008 SHALL have port in_valid_i, input, 1 bit: element valid.
REQ-009 SHALL have port in_ready_o, output, 1 bit: element accepted when in_valid_i and in_ready_o are both high.
REQ-010 SHALL have port sum_o, output, 16 bits: registered FP16 packet sum.
REQ-011 SHALL have port count_o, output, CNT_W bits: number of elements accepted into the packet.
REQ-012 SHALL have port ovf_o, output, 1 bit: packet was closed by MAX_LEN, not by in_last_i.
REQ-013 SHALL have port sum_valid_o, output, 1 bit: result valid.
REQ-014 SHALL have port sum_ready_i, input, 1 bit: result consumed when sum_valid_o and sum_ready_i are both high.
REQ-015 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-016 FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-017 in_ready_o SHALL be 1 in IDLE and ACCUM, 0 in DONE; sum_valid_o SHALL be 1 only in DONE.
REQ-018 On accept in IDLE: acc is loaded directly with in_data_i (no add), cnt becomes 1, ovf is cleared.
REQ-018a Next state after an IDLE accept: DONE if in_last_i is high, otherwise ACCUM.
REQ-019 On accept in ACCUM: acc becomes the adder output, with operand[1] = acc and operand[0] = in_data_i; cnt increments by 1.
REQ-020 Zero handling: an input with bits [14:0] = 0 is not added; acc is held but cnt still increments.
REQ-021 If acc[14:0] = 0 when a non-zero element is accepted, acc is loaded with in_data_i instead of adding; the adder does not handle zero operands.
REQ-022 ACCUM to DONE SHALL occur on an accept with in_last_i high, or on the accept that makes cnt = MAX_LEN; in the latter case with in_last_i low, ovf is set to 1.
REQ-023 DONE to IDLE SHALL occur on sum_ready_i high; while in DONE, sum_o, count_o and ovf_o are held stable.
REQ-024 Latency: sum_valid_o SHALL rise in the cycle after the last element is accepted; throughput is one element per cycle.
REQ-025 in_ready_o SHALL depend only on state, never combinationally on in_valid_i or sum_ready_i.
REQ-026 No element SHALL be accepted in the same cycle the result is consumed; the next packet starts from IDLE one cycle later.
REQ-027 flush_i high SHALL force IDLE and clear acc, cnt and ovf; it has priority over any accept or consume in that cycle, and no element is accepted that cycle.
REQ-028 The adder path SHALL be purely combinational between the acc register and in_data_i; no extra pipeline stage.
REQ-029 sum_o = acc, count_o = cnt and ovf_o = ovf SHALL always be driven directly from registers.

Reset
REQ-030 On rst_ni low, asynchronously: state = IDLE, acc = 0x0000, cnt = 0, ovf = 0.
REQ-030a Outputs during reset: in_ready_o = 1, sum_valid_o = 0, busy_o = 0.
REQ-031 Reset asserted mid-packet SHALL discard the packet with no result emitted.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, ACCUM, DONE) and the FP16 constants: width 16, EXP_BITS 5, MAN_BITS 10.
REQ-033 The block SHALL instantiate exactly one sub-module, new_fp16_add, as the combinational adder; no other arithmetic logic.

Verification
REQ-034 Single element: 0xC500 with last -> sum_o = 0xC500, count_o = 1, ovf_o = 0, sum_valid_o one cycle after accept.
REQ-035 Two elements: 0x3C00 then 0x3C00 with last -> sum_o equals the adder-model output for (0x3C00, 0x3C00), count_o = 2.
REQ-036 Zeros: 0x0000, 0x3C00, 0x8000 with last -> sum_o = 0x3C00, count_o = 3.
REQ-037 Backpressure: sum_ready_i held low for 5 cycles with in_valid_i high -> in_ready_o = 0, sum_o unchanged, result consumed on cycle 6.
REQ-038 Flush after 2 elements, then 0x4000 with last -> sum_o = 0x4000, count_o = 1, no earlier result emitted.
REQ-039 MAX_LEN = 4, five elements of 0x3C00 with no last -> DONE after the 4th with ovf_o = 1, count_o = 4; the 5th opens a new packet.
